// File: rtl/uart_serial_receiver.sv
// UART receiver: 8N1/8E1/8O1 frames, 16x oversampling, small receive FIFO.
// Ports: CLK/RSTN; rx_i serial in; div_i tick divisor; parity_en_i/parity_odd_i
// frame config; data_o/frame_err_o/parity_err_o/valid_o head entry with
// ready_i pop; overrun_o drop pulse; busy_o frame in progress.
module uart_serial_receiver #(
  parameter int FifoDepth = 4,
  parameter int DivWidth  = 16
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                rx_i,
  input  logic [DivWidth-1:0] div_i,
  input  logic                parity_en_i,
  input  logic                parity_odd_i,
  output logic [7:0]          data_o,
  output logic                frame_err_o,
  output logic                parity_err_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                overrun_o,
  output logic                busy_o
);

  localparam int AW = $clog2(FifoDepth);
  localparam logic [AW:0] FullCnt = (AW+1)'(FifoDepth);
  localparam logic [AW:0] CntOne = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [DivWidth-1:0] DivOne = DivWidth'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_n;

  logic                sync1, rx_s;
  logic [DivWidth-1:0] div_q, tcnt;
  logic                par_q, odd_q;
  logic [3:0]          samp;
  logic [2:0]          bitn;
  logic [7:0]          shreg;
  logic                perr_q;
  logic                tick, half, full_bit;
  logic                start, push;

  logic [9:0]    mem [FifoDepth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          full, pop, wr_ok;
  logic [9:0]    head;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rx_s  <= sync1;
    end
  end

  assign tick     = (tcnt == div_q);
  assign half     = tick && (samp == 4'd7);
  assign full_bit = tick && (samp == 4'd15);

  always_comb begin
    state_n = state;
    start   = 1'b0;
    push    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rx_s) begin
          start   = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        // mid-bit recheck rejects short glitches
        if (half) state_n = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (full_bit && bitn == 3'd7)
          state_n = par_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (full_bit) state_n = S_STOP;
      end
      S_STOP: begin
        if (full_bit) begin
          push    = 1'b1;
          state_n = rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      div_q  <= '0;
      par_q  <= 1'b0;
      odd_q  <= 1'b0;
      tcnt   <= '0;
      samp   <= '0;
      bitn   <= '0;
      shreg  <= '0;
      perr_q <= 1'b0;
    end else begin
      if (start) tcnt <= '0;
      else if (tick) tcnt <= '0;
      else tcnt <= tcnt + DivOne;

      if (start) begin
        div_q  <= div_i;
        par_q  <= parity_en_i;
        odd_q  <= parity_odd_i;
        samp   <= '0;
        bitn   <= '0;
        perr_q <= 1'b0;
      end else if (state == S_START && half) begin
        samp <= '0;
      end else if (tick && state != S_IDLE && state != S_BREAK) begin
        // 4-bit wrap lands back on 0 at each bit boundary
        samp <= samp + 4'd1;
      end

      if (state == S_DATA && full_bit) begin
        shreg <= {rx_s, shreg[7:1]};
        bitn  <= bitn + 3'd1;
      end

      if (state == S_PARITY && full_bit)
        perr_q <= ((^shreg) ^ rx_s) != odd_q;
    end
  end

  assign full  = (cnt == FullCnt);
  assign pop   = valid_o & ready_i;
  assign wr_ok = push & (~full | pop);

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= {perr_q, ~rx_s, shreg};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PtrOne;
      if (pop)   rd_ptr <= rd_ptr + PtrOne;
      case ({wr_ok, pop})
        2'b10:   cnt <= cnt + CntOne;
        2'b01:   cnt <= cnt - CntOne;
        default: cnt <= cnt;
      endcase
      overrun_o <= push & full & ~pop;
    end
  end

  // gate storage so an empty FIFO reads as all zeros
  assign valid_o      = (cnt != '0);
  assign head         = valid_o ? mem[rd_ptr] : 10'd0;
  assign data_o       = head[7:0];
  assign frame_err_o  = head[8];
  assign parity_err_o = head[9];
  assign busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_serial_receiver.sv
// Testbench for uart_serial_receiver: directed and random frames
// checked against a queue-based frame model.
module tb_uart_serial_receiver;

  localparam int Depth = 4;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] div = '0;
  logic        pen = 1'b0;
  logic        podd = 1'b0;
  logic        ready = 1'b0;
  logic [7:0]  data_o;
  logic        frame_err_o, parity_err_o;
  logic        valid_o, overrun_o, busy_o;

  uart_serial_receiver #(.FifoDepth(Depth), .DivWidth(16)) dut (
    .CLK(CLK), .RSTN(RSTN), .rx_i(rx), .div_i(div),
    .parity_en_i(pen), .parity_odd_i(podd),
    .data_o(data_o), .frame_err_o(frame_err_o),
    .parity_err_o(parity_err_o), .valid_o(valid_o),
    .ready_i(ready), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } ent_t;

  ent_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int ov_pulses = 0;
  int ov_cycles = 0;
  logic vprev = 1'b0;
  logic ovprev = 1'b0;

  int         cfg_div = 0;
  logic       cfg_pen = 1'b0;
  logic       cfg_odd = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (valid_o && !vprev) rise_cyc = cyc;
    vprev = valid_o;
    if (overrun_o) ov_cycles++;
    if (overrun_o && !ovprev) ov_pulses++;
    ovprev = overrun_o;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drives one frame; the model entry follows the framing rules:
  // parity error when the one-count of data+parity disagrees with
  // the mode, frame error when the stop bit is low, and dropped
  // when the FIFO already holds Depth undrained words.
  task automatic send(input logic [7:0] b, input logic pbit,
                      input int stop_low, input bit scramble);
    int   bt;
    ent_t e;
    bt = 16 * (cfg_div + 1);
    @(negedge CLK);
    div = 16'(cfg_div);
    pen = cfg_pen;
    podd = cfg_odd;
    rx = 1'b0;
    start_cyc = cyc;
    wait_clks(bt);
    if (scramble) begin
      div = 16'($urandom_range(0, 5));
      pen = ~cfg_pen;
      podd = ~cfg_odd;
    end
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(bt);
    end
    if (cfg_pen) begin
      rx = pbit;
      wait_clks(bt);
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      wait_clks(bt * stop_low);
    end
    rx = 1'b1;
    wait_clks(bt);
    div = 16'(cfg_div);
    pen = cfg_pen;
    podd = cfg_odd;
    e.d = b;
    e.fe = (stop_low > 0);
    e.pe = cfg_pen &&
           ((($countones(b) + int'(pbit)) % 2) != int'(cfg_odd));
    if (exp_q.size() < Depth) exp_q.push_back(e);
  endtask

  task automatic drain();
    ent_t e;
    int   n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      while (!valid_o && n < 50) begin
        @(negedge CLK);
        n++;
      end
      chk("pop_valid", 32'(valid_o), 32'd1);
      chk("pop_data", 32'(data_o), 32'(e.d));
      chk("pop_frame_err", 32'(frame_err_o), 32'(e.fe));
      chk("pop_parity_err", 32'(parity_err_o), 32'(e.pe));
      ready = 1'b1;
      @(negedge CLK);
      ready = 1'b0;
    end
    chk("empty_after_drain", 32'(valid_o), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic       pbit;
    int         sl;

    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    chk("rst_flags", 32'({frame_err_o, parity_err_o}), 32'd0);
    wait_clks(3);
    RSTN = 1'b1;
    wait_clks(5);

    // 8N1 at div 0, latency of first word, then back-to-back 0xA3
    cfg_div = 0;
    cfg_pen = 1'b0;
    cfg_odd = 1'b0;
    rise_cyc = -1;
    send(8'h55, 1'b0, 0, 1'b0);
    chk("latency_first_word", 32'(rise_cyc - start_cyc),
        32'(3 + (8 + 16 * 9) * (cfg_div + 1)));
    send(8'hA3, 1'b0, 0, 1'b0);
    drain();

    // short low glitch must be rejected at mid start bit
    @(negedge CLK);
    rx = 1'b0;
    wait_clks(4);
    chk("glitch_busy_seen", 32'(busy_o), 32'd1);
    rx = 1'b1;
    wait_clks(40);
    chk("glitch_busy_idle", 32'(busy_o), 32'd0);
    chk("glitch_no_word", 32'(valid_o), 32'd0);

    // even parity on 0x07: parity bit 0 is wrong, 1 is right
    cfg_pen = 1'b1;
    cfg_odd = 1'b0;
    send(8'h07, 1'b0, 0, 1'b0);
    send(8'h07, 1'b1, 0, 1'b0);
    drain();

    // break: stop held low for 3 bit times, then a clean 0x81
    cfg_pen = 1'b0;
    send(8'h3C, 1'b0, 3, 1'b0);
    send(8'h81, 1'b0, 0, 1'b0);
    drain();

    // overrun: Depth+1 words with no consumer
    cfg_div = 1;
    wait_clks(4);
    ov_pulses = 0;
    ov_cycles = 0;
    for (int i = 0; i <= Depth; i++)
      send(8'($urandom), 1'b0, 0, 1'b0);
    wait_clks(4);
    chk("overrun_pulses", 32'(ov_pulses), 32'd1);
    chk("overrun_width", 32'(ov_cycles), 32'd1);
    drain();

    // randomized frames; config lines scrambled mid-frame
    for (int k = 0; k < 10; k++) begin
      cfg_div = $urandom_range(0, 2);
      cfg_pen = 1'($urandom_range(0, 1));
      cfg_odd = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      pbit = 1'($urandom_range(0, 1));
      sl = ($urandom_range(0, 4) == 0) ? 1 : 0;
      send(b, pbit, sl, 1'b1);
      drain();
    end

    // reset mid-DATA of 0xF0 with one word already queued
    cfg_div = 1;
    cfg_pen = 1'b0;
    send(8'h99, 1'b0, 0, 1'b0);
    @(negedge CLK);
    div = 16'(cfg_div);
    rx = 1'b0;
    wait_clks(32);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'hF0 >> i);
      wait_clks(32);
    end
    rx = 1'b1;
    wait_clks(16);
    #2;
    RSTN = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_data", 32'(data_o), 32'd0);
    exp_q.delete();
    wait_clks(3);
    chk("midrst_overrun", 32'(overrun_o), 32'd0);
    RSTN = 1'b1;
    wait_clks(40);
    chk("postrst_idle", 32'(busy_o), 32'd0);
    chk("postrst_empty", 32'(valid_o), 32'd0);
    send(8'h12, 1'b0, 0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
